// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: conditions the start/stop and lap/clear buttons,
// sequences the Timer through IDLE/RUN/STOPPED/LAP and selects whether the
// display chain sees the live count or a frozen lap snapshot.
module stopwatch_ctrl #(
  parameter int NUMCELLS        = 4,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  btn_ss,
  input  logic                  btn_lap,
  input  logic [4*NUMCELLS-1:0] elapsed_in,
  output logic                  timer_rst,
  output logic                  timer_pause,
  output logic [4*NUMCELLS-1:0] disp_val,
  output logic [1:0]            state
);

  localparam int DW = 4 * NUMCELLS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2,
    ST_LAP     = 2'd3
  } state_t;

  // Bit 0 carries start/stop, bit 1 carries lap/clear.
  logic [1:0]    btn_raw_s;
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    level_r;
  logic [1:0]    press_r;
  logic [1:0]    take_s;
  logic [CW-1:0] cnt_r [2];

  state_t        state_r;
  state_t        state_next_s;
  logic          lap_capture_s;
  logic [DW-1:0] lap_reg_r;
  logic [DW-1:0] disp_val_r;
  logic          timer_rst_r;
  logic          timer_pause_r;

  assign btn_raw_s = {btn_lap, btn_ss};

  // A button level is accepted once the synced value has disagreed with it long enough.
  always_comb begin
    take_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if ((sync2_r[i] != level_r[i]) && (cnt_r[i] == CNT_LAST)) begin
        take_s[i] = 1'b1;
      end else begin
        take_s[i] = 1'b0;
      end
    end
  end

  // Synchronise, debounce and edge-detect both buttons with identical logic.
  always_ff @(posedge clock) begin
    if (rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      level_r <= 2'b00;
      press_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
      // Only a newly accepted high level is a press; releases are dropped.
      press_r <= take_s & sync2_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (take_s[i]) begin
          level_r[i] <= sync2_r[i];
          cnt_r[i]   <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Next-state decode; start/stop takes priority over lap/clear.
  always_comb begin
    state_next_s  = state_r;
    lap_capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (press_r[0]) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (press_r[0]) begin
          state_next_s = ST_STOPPED;
        end else if (press_r[1]) begin
          state_next_s  = ST_LAP;
          lap_capture_s = 1'b1;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_LAP: begin
        if (press_r[0]) begin
          state_next_s = ST_STOPPED;
        end else if (press_r[1]) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_LAP;
        end
      end
      ST_STOPPED: begin
        if (press_r[0]) begin
          state_next_s = ST_RUN;
        end else if (press_r[1]) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STOPPED;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register, lap snapshot, display mux and timer controls.
  // Timer controls are registered from the next state so they track the state register exactly.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      lap_reg_r     <= {DW{1'b0}};
      disp_val_r    <= {DW{1'b0}};
      timer_rst_r   <= 1'b1;
      timer_pause_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      if (lap_capture_s) begin
        lap_reg_r <= elapsed_in;
      end else begin
        lap_reg_r <= lap_reg_r;
      end
      disp_val_r    <= (state_r == ST_LAP) ? lap_reg_r : elapsed_in;
      timer_rst_r   <= (state_next_s == ST_IDLE);
      timer_pause_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_STOPPED);
    end
  end

  assign state       = state_r;
  assign disp_val    = disp_val_r;
  assign timer_rst   = timer_rst_r;
  assign timer_pause = timer_pause_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed button scenarios, a cycle-level
// reference model compared every cycle, and literal spot checks.
module tb_stopwatch_ctrl;

  localparam int D  = 4;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_ss = 1'b0;
  logic        btn_lap = 1'b0;
  logic [15:0] elapsed_in = 16'h0000;
  logic        timer_rst;
  logic        timer_pause;
  logic [15:0] disp_val;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int chg      = 0;
  int cyc      = 0;
  logic [1:0] prev_state = 2'd0;

  stopwatch_ctrl #(.NUMCELLS(NC), .DEBOUNCE_CYCLES(D)) dut (
    .clock(clk), .rst(rst), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .elapsed_in(elapsed_in), .timer_rst(timer_rst), .timer_pause(timer_pause),
    .disp_val(disp_val), .state(state)
  );

  // Clock generation.
  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted when the last D synchronised samples
  // (raw samples delayed by two clocks) all disagree with the current level.
  function automatic bit accept(input bit [D+1:0] h, input bit lvl);
    if (lvl) accept = ~|h[D+1:2];
    else     accept = &h[D+1:2];
  endfunction

  // Model and per-cycle comparison of every output.
  initial begin
    bit [D+1:0] h_ss, h_lap;
    bit lv_ss, lv_lap, p_ss, p_lap, armed;
    bit s_rst, s_ss, s_lap;
    logic [15:0] s_el, m_lap, m_disp;
    int m_st, nst;
    h_ss = '0; h_lap = '0; lv_ss = 0; lv_lap = 0; p_ss = 0; p_lap = 0; armed = 0;
    m_lap = 16'h0; m_disp = 16'h0; m_st = 0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_ss = btn_ss; s_lap = btn_lap; s_el = elapsed_in;
      if (s_rst) begin
        h_ss = '0; h_lap = '0; lv_ss = 0; lv_lap = 0; p_ss = 0; p_lap = 0;
        m_st = 0; m_lap = 16'h0; m_disp = 16'h0; armed = 1;
      end else begin
        m_disp = (m_st == 3) ? m_lap : s_el;
        nst = m_st;
        if (p_ss) begin
          nst = (m_st == 0 || m_st == 2) ? 1 : 2;
        end else if (p_lap) begin
          case (m_st)
            1: begin nst = 3; m_lap = s_el; end
            2: nst = 0;
            3: nst = 1;
            default: nst = m_st;
          endcase
        end
        m_st = nst;
        h_ss  = {h_ss[D:0], s_ss};
        h_lap = {h_lap[D:0], s_lap};
        p_ss = 0; p_lap = 0;
        if (accept(h_ss, lv_ss))   begin p_ss  = ~lv_ss;  lv_ss  = ~lv_ss;  end
        if (accept(h_lap, lv_lap)) begin p_lap = ~lv_lap; lv_lap = ~lv_lap; end
      end
      @(negedge clk);
      if (armed) begin
        check("model state", 32'(state), 32'(m_st));
        check("model timer_rst", 32'(timer_rst), 32'(m_st == 0));
        check("model timer_pause", 32'(timer_pause), 32'(m_st == 0 || m_st == 2));
        check("model disp_val", 32'(disp_val), 32'(m_disp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (state != prev_state) chg++;
    prev_state = state;
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int maxc, output int c);
    c = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (state == tgt) begin
        c = i;
        break;
      end
    end
  endtask

  task automatic press(input bit lap, input logic [1:0] tgt, input string nm);
    int c;
    if (lap) btn_lap = 1'b1; else btn_ss = 1'b1;
    wait_state(tgt, 12, c);
    check(nm, 32'(c >= 6 && c <= 8), 32'd1);
    btn_lap = 1'b0; btn_ss = 1'b0;
    repeat (10) tick();
  endtask

  // Directed stimulus with literal expectations.
  initial begin
    // 1: reset and idle
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    check("idle state", 32'(state), 32'd0);
    check("idle timer_rst", 32'(timer_rst), 32'd1);
    check("idle timer_pause", 32'(timer_pause), 32'd1);
    check("idle disp_val", 32'(disp_val), 32'h0000);

    // 2: clean start press held 10 cycles
    btn_ss = 1'b1;
    wait_state(2'd1, 12, cyc);
    check("start latency window", 32'(cyc >= 6 && cyc <= 8), 32'd1);
    check("run timer_rst", 32'(timer_rst), 32'd0);
    check("run timer_pause", 32'(timer_pause), 32'd0);
    if (cyc > 0 && cyc < 10) repeat (10 - cyc) tick();
    btn_ss = 1'b0;
    elapsed_in = 16'h0042;
    tick();
    check("run disp follows", 32'(disp_val), 32'h0042);
    repeat (10) tick();

    // 3: lap snapshot, then return to run
    elapsed_in = 16'h0123;
    tick();
    press(1'b1, 2'd3, "lap latency window");
    elapsed_in = 16'h0130; tick();
    elapsed_in = 16'h0140; tick();
    elapsed_in = 16'h0150; tick();
    check("lap state", 32'(state), 32'd3);
    check("lap disp held", 32'(disp_val), 32'h0123);
    check("lap timer_pause", 32'(timer_pause), 32'd0);
    press(1'b1, 2'd1, "lap exit window");
    check("run after lap state", 32'(state), 32'd1);
    check("run after lap disp", 32'(disp_val), 32'h0150);

    // 4: bounce shorter than the debounce window, then bounce plus stable high
    chg = 0;
    for (int i = 0; i < 15; i++) begin
      btn_ss = ~btn_ss;
      tick(); tick();
    end
    btn_ss = 1'b0;
    repeat (10) tick();
    check("bounce no change count", 32'(chg), 32'd0);
    check("bounce state", 32'(state), 32'd1);
    chg = 0;
    for (int i = 0; i < 15; i++) begin
      btn_ss = ~btn_ss;
      tick(); tick();
    end
    repeat (8) tick();
    btn_ss = 1'b0;
    repeat (10) tick();
    check("bounce+stable change count", 32'(chg), 32'd1);
    check("bounce+stable state", 32'(state), 32'd2);
    press(1'b0, 2'd1, "resume window");

    // 5: simultaneous presses, start/stop wins; then clear
    elapsed_in = 16'h0777;
    chg = 0;
    btn_lap = 1'b1;
    press(1'b0, 2'd2, "both press window");
    check("both press single change", 32'(chg), 32'd1);
    check("both press state", 32'(state), 32'd2);
    press(1'b1, 2'd0, "clear window");
    check("clear timer_rst", 32'(timer_rst), 32'd1);

    // 6: reset while in LAP with start/stop held
    elapsed_in = 16'h0200;
    press(1'b0, 2'd1, "restart window");
    press(1'b1, 2'd3, "lap2 window");
    btn_ss = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset state", 32'(state), 32'd0);
    check("reset disp_val", 32'(disp_val), 32'h0000);
    check("reset timer_rst", 32'(timer_rst), 32'd1);
    wait_state(2'd1, 12, cyc);
    check("held button window", 32'(cyc >= 6 && cyc <= 8), 32'd1);
    repeat (4) tick();
    btn_ss = 1'b0;
    chg = 0;
    repeat (12) tick();
    check("held button once", 32'(chg), 32'd0);
    check("held button state", 32'(state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the Timer → TimerDecode → SevenSeg display chain as a stopwatch. It debounces two raw push-buttons (start/stop, lap/clear) and drives the Timer's `rst`/`pause` inputs. It also selects whether the display path receives the live `elapsed` value or a frozen lap snapshot. It sits between the board buttons and the Timer, and between the Timer output and TimerDecode.

Parameters:
- NUMCELLS, 4, number of BCD display cells; data width is 4*NUMCELLS.
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a button level change (10 ms at 12 MHz). Minimum 2. Counter width is $clog2(DEBOUNCE_CYCLES).

Ports:
- clock  input  1  system clock, 12 MHz.
- rst  input  1  synchronous, active-high reset.
- btn_ss  input  1  raw start/stop button, asynchronous, active-high.
- btn_lap  input  1  raw lap/clear button, asynchronous, active-high.
- elapsed_in  input  4*NUMCELLS  live BCD count from Timer `elapsed`.
- timer_rst  output  1  to Timer `rst`.
- timer_pause  output  1  to Timer `pause`.
- disp_val  output  4*NUMCELLS  BCD value to TimerDecode `in`.
- state  output  2  FSM state: 0=IDLE, 1=RUN, 2=STOPPED, 3=LAP.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, disp_val=0, lap_reg=0.
  - Synchronizer flops=0, debounced levels=0, debounce counters=0, press pulses=0.
  - Reset mid-operation abandons any state immediately.
- Input conditioning, per button, identical logic:
  - 2-flop synchronizer.
  - Debounce counter clears whenever the synced value equals the debounced level.
  - Otherwise the counter increments. On the cycle it reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced level takes the synced value and the counter clears.
  - Press = registered one-cycle pulse on a 0→1 transition of the debounced level. Releases generate nothing.
  - A button held through reset release yields one press after it is debounced.
  - Bounce shorter than DEBOUNCE_CYCLES consecutive cycles: no press.
- Latency: a raw edge held stable produces a state change 2 + DEBOUNCE_CYCLES + 1 cycles later (±1). The bench checks a window, not an exact cycle.
- FSM (registered). Transitions occur on the edge where the press pulse is high:
  - IDLE: ss → RUN. lap ignored.
  - RUN: ss → STOPPED. lap → LAP, and lap_reg ← elapsed_in on the same edge.
  - LAP: ss → STOPPED (lap_reg retained but not displayed). lap → RUN.
  - STOPPED: ss → RUN (resume, no clear). lap → IDLE (clear).
  - Both presses on the same cycle: ss wins, lap discarded.
- Outputs, decoded from the state register (no extra latency):
  - timer_rst = 1 in IDLE, else 0.
  - timer_pause = 1 in IDLE and STOPPED; 0 in RUN and LAP. The timer keeps counting during LAP.
- disp_val (registered, 1-cycle latency): lap_reg when state==LAP, else elapsed_in. It updates every cycle.
- Timer wrap-around is passed through unmodified; the controller does not detect or clamp it.
- No arithmetic on BCD data; values are copied bit-exact.

Test Plan (DEBOUNCE_CYCLES=4, NUMCELLS=4):
1. Reset, then idle 20 cycles → state=0, timer_rst=1, timer_pause=1, disp_val=16'h0000.
2. Clean btn_ss pulse held 10 cycles → state=1 within 6–8 cycles of the raw edge; timer_rst=0, timer_pause=0; disp_val follows elapsed_in with 1-cycle lag.
3. In RUN with elapsed_in=16'h0123, press btn_lap; elapsed_in then ramps to 16'h0150 → state=3, disp_val held at 16'h0123, timer_pause=0. Press btn_lap again → state=1, disp_val=16'h0150.
4. Bounce test: btn_ss toggling every 2 cycles for 30 cycles, then low → no state change. Same glitch followed by 8 stable high cycles → exactly one transition.
5. From RUN: press both buttons on the same raw edge → state=2 (STOPPED) and lap_reg unchanged. Press btn_lap → state=0, timer_rst=1.
6. Assert rst for 1 cycle while in LAP with btn_ss held high → state=0, disp_val=0 next cycle. After the debounce window, state=1 (held button counted once).
